// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-issue SRAM controller.
// Optional WAIT-state timeout abort is built when SRAM_ARB_TIMEOUT_EN is defined.
module sram_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        p0_req,
   input  logic        p0_wr,
   input  logic [19:0] p0_addr,
   input  logic [15:0] p0_wdata,
   output logic        p0_ack,
   output logic [15:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_wr,
   input  logic [19:0] p1_addr,
   input  logic [15:0] p1_wdata,
   output logic        p1_ack,
   output logic [15:0] p1_rdata,
   output logic        p1_err,
   output logic        mem_request,
   output logic        mem_wr,
   output logic [19:0] mem_addr,
   output logic [15:0] mem_w_value,
   input  logic [15:0] mem_r_value,
   input  logic        mem_valid,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   gnt;
   logic   grant_take;
   logic   grant_port;
   logic   capture;
   logic   timeout_hit;

   if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("sram_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   // Abort decided one cycle early so DONE lands as the count reaches TIMEOUT_CYCLES-1.
   assign timeout_hit = (state == WAIT) && !mem_valid && (tmo_cnt >= TMO_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == ISSUE)
            tmo_cnt <= '0;
         else if (state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (state != DONE)
            err_q <= timeout_hit;
      end
   end

   assign p0_err = p0_ack & err_q;
   assign p1_err = p1_ack & err_q;
`else
   assign timeout_hit = 1'b0;
   assign p0_err      = 1'b0;
   assign p1_err      = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      grant_take = 1'b0;
      grant_port = last_grant;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (p0_req || p1_req) begin
               grant_take = 1'b1;
               grant_port = (p0_req && p1_req) ? ~last_grant : p1_req;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_valid) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_valid) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (timeout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         gnt         <= 1'b0;
         mem_wr      <= 1'b0;
         mem_addr    <= '0;
         mem_w_value <= '0;
         p0_rdata    <= '0;
         p1_rdata    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_take) begin
            last_grant  <= grant_port;
            gnt         <= grant_port;
            mem_wr      <= grant_port ? p1_wr    : p0_wr;
            mem_addr    <= grant_port ? p1_addr  : p0_addr;
            mem_w_value <= grant_port ? p1_wdata : p0_wdata;
         end
         if (capture && !mem_wr) begin
            if (gnt)
               p1_rdata <= mem_r_value;
            else
               p0_rdata <= mem_r_value;
         end
      end
   end

   assign mem_request = (state == ISSUE);
   assign busy        = (state != IDLE);
   assign p0_ack      = (state == DONE) && !gnt;
   assign p1_ack      = (state == DONE) &&  gnt;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level round-robin model.
module tb_sram_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        p0_req, p0_wr, p1_req, p1_wr;
   logic [19:0] p0_addr, p1_addr;
   logic [15:0] p0_wdata, p1_wdata;
   logic        p0_ack, p1_ack, p0_err, p1_err;
   logic [15:0] p0_rdata, p1_rdata;
   logic        mem_request, mem_wr, mem_valid, busy;
   logic [19:0] mem_addr;
   logic [15:0] mem_w_value, mem_r_value;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference model state: last served port and per-port last read data.
   int          lg_m;
   logic [15:0] rd_m [2];

   sram_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_request(mem_request), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_w_value(mem_w_value), .mem_r_value(mem_r_value),
      .mem_valid(mem_valid), .busy(busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic req, input logic wr,
                           input logic [19:0] addr, input logic [15:0] wd);
      if (p == 0) begin
         p0_req = req; p0_wr = wr; p0_addr = addr; p0_wdata = wd;
      end else begin
         p1_req = req; p1_wr = wr; p1_addr = addr; p1_wdata = wd;
      end
   endtask

   task automatic model_reset();
      lg_m  = 1;
      rd_m[0] = '0;
      rd_m[1] = '0;
   endtask

   task automatic chk_rdata(input string tag);
      chk({tag, "_rdata0"}, p0_rdata, rd_m[0]);
      chk({tag, "_rdata1"}, p1_rdata, rd_m[1]);
   endtask

   // One full transaction from the IDLE sampling edge; controller answers d cycles after ISSUE.
   task automatic do_txn(input int unsigned d, input logic [15:0] rval, input logic stray);
      int          g;
      logic        ewr;
      logic [19:0] eaddr;
      logic [15:0] ewd;
      if (p0_req && p1_req) g = (lg_m == 1) ? 0 : 1;
      else if (p0_req)      g = 0;
      else                  g = 1;
      ewr   = (g == 1) ? p1_wr    : p0_wr;
      eaddr = (g == 1) ? p1_addr  : p0_addr;
      ewd   = (g == 1) ? p1_wdata : p0_wdata;
      tick();
      chk("issue_req", mem_request, 1);
      chk("issue_wr", mem_wr, ewr);
      chk("issue_addr", mem_addr, eaddr);
      chk("issue_wval", mem_w_value, ewd);
      chk("issue_busy", busy, 1);
      for (int unsigned i = 0; i < d; i++) begin
         tick();
         chk("wait_req", mem_request, 0);
         chk("wait_addr", mem_addr, eaddr);
         chk("wait_wval", mem_w_value, ewd);
         chk("wait_wr", mem_wr, ewr);
         chk("wait_ack", {p0_ack, p1_ack}, 0);
      end
      mem_valid = 1'b1;
      mem_r_value = rval;
      tick();
      mem_valid = 1'b0;
      mem_r_value = 16'($urandom);
      if (!ewr) rd_m[g] = rval;
      lg_m = g;
      chk("done_ack0", p0_ack, (g == 0));
      chk("done_ack1", p1_ack, (g == 1));
      chk("done_err", {p0_err, p1_err}, 0);
      chk("done_busy", busy, 1);
      chk("done_req", mem_request, 0);
      chk_rdata("done");
      set_port(g, 1'b0, ewr, eaddr, ewd);
      if (stray) begin
         mem_valid = 1'b1;
         mem_r_value = 16'($urandom);
      end
      tick();
      mem_valid = 1'b0;
      chk("idle_ack", {p0_ack, p1_ack}, 0);
      chk("idle_busy", busy, 0);
      chk_rdata("idle");
   endtask

   initial begin
      i_rst_n = 1'b0;
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      mem_valid = 1'b0;
      mem_r_value = '0;
      model_reset();
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_mreq", mem_request, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_mwr", mem_wr, 0);
      chk("rst_mwval", mem_w_value, 0);
      chk("rst_ack", {p0_ack, p1_ack, p0_err, p1_err}, 0);
      chk_rdata("rst");
      i_rst_n = 1'b1;

      // Simultaneous requests right after reset: p0 first, then p1, then round robin.
      set_port(0, 1'b1, 1'b1, 20'h00005, 16'h1234);
      set_port(1, 1'b1, 1'b0, 20'h00006, 16'h0000);
      do_txn(3, 16'h7777, 1'b0);
      do_txn(2, 16'h5A5A, 1'b0);
      set_port(0, 1'b1, 1'b0, 20'h00100, 16'h0000);
      set_port(1, 1'b1, 1'b0, 20'h00200, 16'h0000);
      do_txn(1, 16'h1111, 1'b0);
      do_txn(4, 16'h2222, 1'b0);

      // mem_valid in IDLE must be ignored.
      mem_valid = 1'b1;
      mem_r_value = 16'hDEAD;
      tick();
      mem_valid = 1'b0;
      chk("stray_idle_busy", busy, 0);
      chk("stray_idle_ack", {p0_ack, p1_ack}, 0);
      chk_rdata("stray_idle");

      // Port 0 read, 8-cycle controller latency.
      set_port(0, 1'b1, 1'b0, 20'h00010, 16'h0000);
      do_txn(8, 16'hBEEF, 1'b1);
      // Port 1 write at top of address space.
      set_port(1, 1'b1, 1'b1, 20'hFFFFF, 16'hA5A5);
      do_txn(5, 16'h3C3C, 1'b0);
      // mem_valid in the ISSUE cycle.
      set_port(1, 1'b1, 1'b0, 20'h00ABC, 16'h0000);
      do_txn(0, 16'h1357, 1'b0);
      set_port(0, 1'b1, 1'b0, 20'h00ABD, 16'h0000);
      do_txn(0, 16'h2468, 1'b1);

      // Reset in WAIT with completion pending.
      set_port(0, 1'b1, 1'b0, 20'h00022, 16'h0000);
      tick();
      tick();
      tick();
      i_rst_n = 1'b0;
      mem_valid = 1'b1;
      mem_r_value = 16'h9999;
      #1;
      model_reset();
      chk("arst_busy", busy, 0);
      chk("arst_mreq", mem_request, 0);
      chk("arst_maddr", mem_addr, 0);
      chk("arst_mwr", mem_wr, 0);
      chk("arst_mwval", mem_w_value, 0);
      chk("arst_ack", {p0_ack, p1_ack, p0_err, p1_err}, 0);
      chk_rdata("arst");
      set_port(0, 1'b0, 1'b0, '0, '0);
      tick();
      i_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("arst_late_ack", {p0_ack, p1_ack}, 0);
         chk("arst_late_busy", busy, 0);
      end
      mem_valid = 1'b0;
      chk_rdata("arst_late");

      // Randomized traffic against the model.
      for (int n = 0; n < 40; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!((p == 0) ? p0_req : p1_req)) begin
               set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        20'($urandom), 16'($urandom));
            end
         end
         if (!p0_req && !p1_req) begin
            set_port(int'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                     20'($urandom), 16'($urandom));
         end
         do_txn($urandom_range(0, 10), 16'($urandom), ($urandom_range(0, 3) == 0));
      end
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      tick();

`ifdef SRAM_ARB_TIMEOUT_EN
      // Controller never answers: abort with err alongside ack 16 cycles after ISSUE.
      set_port(0, 1'b1, 1'b0, 20'h00033, 16'h0000);
      tick();
      chk("tmo_issue", mem_request, 1);
      for (int k = 1; k < 16; k++) begin
         tick();
         chk("tmo_wait_ack", {p0_ack, p0_err}, 0);
      end
      tick();
      chk("tmo_ack", p0_ack, 1);
      chk("tmo_err", p0_err, 1);
      chk("tmo_p1", {p1_ack, p1_err}, 0);
      chk_rdata("tmo");
      set_port(0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("tmo_idle", {busy, p0_ack, p0_err}, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum WAIT-state cycles before a transaction is aborted (used only when SRAM_ARB_TIMEOUT_EN is defined).
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 p0_req, p1_req  in  1 each  port request; held high until the matching ack; port 0 = core, port 1 = recognition engine.
REQ-005 p0_wr, p1_wr  in  1 each  1 = write, 0 = read; valid while req is high.
REQ-006 p0_addr, p1_addr  in  20 each  word address.
REQ-007 p0_wdata, p1_wdata  in  16 each  write data.
REQ-008 p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
REQ-009 p0_rdata, p1_rdata  out  16 each  last read data returned to that port.
REQ-010 p0_err, p1_err  out  1 each  timeout flag; valid only while the matching ack is high.
REQ-011 mem_request  out  1  one-cycle issue strobe to the SRAM controller.
REQ-012 mem_wr, mem_addr[19:0], mem_w_value[15:0]  out  transaction fields to the SRAM controller.
REQ-013 mem_r_value  in  16  read data from the SRAM controller.
REQ-014 mem_valid  in  1  controller completion pulse.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; IDLE is the only reset state.
REQ-017 IDLE transitions:
- No request: stay in IDLE.
- Exactly one requester high: grant it, latch its wr/addr/wdata into internal registers, go to ISSUE.
- Both high: grant the port opposite to last_grant.
REQ-018 last_grant updates to the granted port on every grant; its reset value is 1, so port 0 wins the first contention.
REQ-019 ISSUE behaviour:
- mem_request = 1 for exactly this one cycle.
- mem_wr/mem_addr/mem_w_value driven from the latched registers.
- Next state: WAIT.
REQ-020 WAIT behaviour:
- mem_request = 0; latched fields stay stable on mem_wr/mem_addr/mem_w_value.
- mem_valid = 1: go to DONE; on a read, capture mem_r_value into the granted port's rdata.
REQ-021 A mem_valid arriving during ISSUE is treated as if it arrived in WAIT, with the same capture and a transition to DONE.
REQ-022 DONE behaviour:
- Granted port's ack = 1 for this one cycle; next state is IDLE.
- Requests are not sampled in DONE, so a requester that drops req after ack is never regranted.
REQ-023 mem_valid in IDLE or DONE is ignored.
REQ-024 Outside ISSUE/WAIT, mem_addr/mem_wr/mem_w_value hold their last latched values.
REQ-025 Latency:
- req sampled in IDLE at cycle T; mem_request at T+1.
- mem_valid at cycle V gives ack at V+1.
- Back-to-back grant is possible at V+3 at the earliest.
REQ-026 A write never modifies any rdata register.
REQ-027 The non-granted port's req, wr, addr and wdata are ignored until the next IDLE.
REQ-028 A port's rdata is changed only by completion of its own read.

Reset
REQ-029 Asserting i_rst_n low, at any time including mid-transaction, immediately forces:
- state = IDLE; last_grant = 1; timeout counter = 0.
- mem_request = 0, mem_wr = 0, mem_addr = 0, mem_w_value = 0.
- p0/p1_ack = 0, p0/p1_err = 0, p0/p1_rdata = 0, busy = 0.
REQ-030 After reset deassertion, the first grant decision occurs on the first rising edge with a request high.

Configuration
REQ-031 With SRAM_ARB_TIMEOUT_EN defined:
- A counter clears on entry to WAIT and increments each WAIT cycle.
- If it reaches TIMEOUT_CYCLES-1 without mem_valid, go to DONE with the granted port's err = 1 alongside ack; rdata is unchanged.
REQ-032 Without SRAM_ARB_TIMEOUT_EN: no counter is built, p0_err/p1_err are tied 0, and WAIT persists until mem_valid.

Verification
REQ-033 Port 0 read, addr 0x00010, controller returns 0xBEEF after 8 cycles -> mem_request one pulse; p0_ack one pulse; p0_rdata = 0xBEEF; p1 outputs unchanged.
REQ-034 Both ports request in the same cycle right after reset (p0 write 0x1234 @0x00005, p1 read @0x00006) -> p0 served first, then p1; the next simultaneous pair serves p0 again (round robin).
REQ-035 Port 1 write 0xA5A5 @0xFFFFF -> mem_addr = 0xFFFFF and mem_w_value = 0xA5A5 stable from ISSUE through WAIT; p1_rdata unchanged; p1_ack one pulse.
REQ-036 Reset asserted in WAIT with mem_valid pending -> busy = 0 and all outputs at reset values immediately; a later mem_valid produces no ack.
REQ-037 SRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, mem_valid never arrives -> p0_ack and p0_err pulse together 16 cycles after ISSUE; FSM back to IDLE.
REQ-038 mem_valid asserted in the ISSUE cycle -> ack on the next cycle; rdata captured correctly.
